dac_playback_ctrl: RTL and testbench

Final rf_clk-domain stage of the DAC playback path. It consumes the 256b expanded sample stream from the DAC data path, buffers it in a small internal FIFO, and presents a continuous sample stream to the RF data converter DAC AXIS port. It gates playback with a prefill threshold, substitutes an idle pattern on underflow, stops after a programmed word count, and reports status.

---
 rtl/dac_playback_ctrl_if.sv | 11 +
 rtl/dac_playback_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dac_playback_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_playback_ctrl_if.sv
// rtl/dac_playback_ctrl_if.sv - sample stream bundle with master (producer) and slave (consumer) views
interface dac_playback_ctrl_if #(
   parameter int DATA_W = 256
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/dac_playback_ctrl.sv
// rtl/dac_playback_ctrl.sv - DAC playback stage: prefill-gated FIFO, idle pattern on underflow, word-count stop
module dac_playback_ctrl #(
   parameter int DATA_W     = 256,
   parameter int FIFO_DEPTH = 16,
   parameter int PREFILL    = 8,
   parameter int CNT_W      = 32
) (
   input  logic                rf_clk,
   input  logic                rf_rstb,
   dac_playback_ctrl_if.slave  s_axis,
   dac_playback_ctrl_if.master m_axis,
   input  logic                play_en,
   input  logic                idle_mode,
   input  logic [CNT_W-1:0]    stop_count,
   input  logic                stat_clr,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    words_sent,
   output logic [CNT_W-1:0]    underflow_cnt,
   output logic                underflow_flag
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   if (PREFILL < 1 || PREFILL > FIFO_DEPTH) begin : g_bad_prefill
      $error("PREFILL must lie in 1..FIFO_DEPTH");
   end
   if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_PLAY    = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [LW-1:0]       level_q, level_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d, last_q, last_d;
   logic                tvalid_q;
   logic [CNT_W-1:0]    stop_q, stop_d, ws_q, ws_d, ucnt_q, ucnt_d;
   logic                uflag_q, uflag_d;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];

   logic                push, pop, underflow, live, flush;
   logic [DATA_W-1:0]   idle_pat;
   logic [CNT_W-1:0]    ws_inc;

   assign s_axis.tready = ((state_q == ST_PREFILL) || (state_q == ST_PLAY))
                          && (level_q < LW'(FIFO_DEPTH));
   assign push      = s_axis.tvalid && s_axis.tready;
   // Dropping play_en freezes the pop side in the same cycle so nothing leaks out of a cancelled run.
   assign live      = (state_q == ST_PLAY) && play_en;
   assign pop       = live && m_axis.tready && (level_q != '0);
   assign underflow = live && m_axis.tready && (level_q == '0);
   assign idle_pat  = idle_mode ? last_q : '0;
   assign ws_inc    = ws_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      stop_d  = stop_q;
      ws_d    = ws_q;
      tdata_d = idle_pat;
      last_d  = last_q;
      ucnt_d  = ucnt_q;
      uflag_d = uflag_q;

      if (pop) begin
         tdata_d = mem[rd_ptr_q];
         last_d  = mem[rd_ptr_q];
         ws_d    = ws_inc;
      end else if (live && !m_axis.tready) begin
         tdata_d = tdata_q;
      end

      if (stat_clr) begin
         ucnt_d  = '0;
         uflag_d = 1'b0;
      end else if (underflow) begin
         if (ucnt_q != '1) ucnt_d = ucnt_q + CNT_W'(1);
         uflag_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (play_en) begin
               state_d = ST_PREFILL;
               ws_d    = '0;
               stop_d  = stop_count;
            end
         end
         ST_PREFILL: if (level_q >= LW'(PREFILL)) state_d = ST_PLAY;
         ST_PLAY:    if (pop && (stop_q != '0) && (ws_inc == stop_q)) state_d = ST_DONE;
         ST_DONE:    state_d = ST_DONE;
         default:    state_d = ST_IDLE;
      endcase

      if (!play_en) state_d = ST_IDLE;
   end

   assign flush = (state_d == ST_IDLE);

   always_comb begin
      level_d  = level_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         level_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      level_d = level_q + LW'(1);
         else if (pop && !push) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge rf_clk) begin
      if (push) mem[wr_ptr_q] <= s_axis.tdata;
   end

   always_ff @(posedge rf_clk or negedge rf_rstb) begin
      if (!rf_rstb) begin
         state_q  <= ST_IDLE;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tdata_q  <= '0;
         last_q   <= '0;
         tvalid_q <= 1'b0;
         stop_q   <= '0;
         ws_q     <= '0;
         ucnt_q   <= '0;
         uflag_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         tdata_q  <= tdata_d;
         last_q   <= last_d;
         tvalid_q <= 1'b1;
         stop_q   <= stop_d;
         ws_q     <= ws_d;
         ucnt_q   <= ucnt_d;
         uflag_q  <= uflag_d;
      end
   end

   assign m_axis.tvalid  = tvalid_q;
   assign m_axis.tdata   = tdata_q;
   assign state          = state_q;
   assign words_sent     = ws_q;
   assign underflow_cnt  = ucnt_q;
   assign underflow_flag = uflag_q;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// tb/tb_dac_playback_ctrl.sv - queue-model checked bench for dac_playback_ctrl
module tb_dac_playback_ctrl;
   localparam int DW = 256, CW = 32, DEPTH = 16, PF = 8;

   logic          rf_clk;
   logic          rf_rstb;
   logic          play_en, idle_mode, stat_clr;
   logic [CW-1:0] stop_count;
   logic [1:0]    state;
   logic [CW-1:0] words_sent, underflow_cnt;
   logic          underflow_flag;

   dac_playback_ctrl_if #(.DATA_W(DW)) s_if ();
   dac_playback_ctrl_if #(.DATA_W(DW)) m_if ();

   dac_playback_ctrl #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PREFILL(PF), .CNT_W(CW)) dut (
      .rf_clk        (rf_clk),
      .rf_rstb       (rf_rstb),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .play_en       (play_en),
      .idle_mode     (idle_mode),
      .stop_count    (stop_count),
      .stat_clr      (stat_clr),
      .state         (state),
      .words_sent    (words_sent),
      .underflow_cnt (underflow_cnt),
      .underflow_flag(underflow_flag)
   );

   initial rf_clk = 1'b0;
   always #5 rf_clk = ~rf_clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: the FIFO is a queue, state is a plain integer 0..3.
   int              mst;
   logic [DW-1:0]   q[$];
   logic [DW-1:0]   m_data, m_last;
   logic            m_valid, m_flag;
   int unsigned     m_ws, m_stop, m_ucnt;
   int unsigned     src_next;

   task automatic model_step();
      int          lvl, ns;
      bit          trdy, push, pop, uf, live;
      logic [DW-1:0] w, idle_pat;
      lvl      = q.size();
      trdy     = (mst == 1 || mst == 2) && lvl < DEPTH;
      push     = s_if.tvalid && trdy;
      live     = (mst == 2) && play_en;
      pop      = live && m_if.tready && lvl > 0;
      uf       = live && m_if.tready && lvl == 0;
      idle_pat = idle_mode ? m_last : '0;
      ns       = mst;
      if (pop) begin
         w = q.pop_front();
         m_data = w;
         m_last = w;
         m_ws++;
      end else if (!(live && !m_if.tready)) begin
         m_data = idle_pat;
      end
      if (push) begin
         q.push_back(s_if.tdata);
         src_next++;
      end
      if (stat_clr) begin
         m_ucnt = 0;
         m_flag = 1'b0;
      end else if (uf) begin
         if (m_ucnt != 32'hFFFF_FFFF) m_ucnt++;
         m_flag = 1'b1;
      end
      if (mst == 0 && play_en) begin
         ns = 1; m_ws = 0; m_stop = stop_count;
      end else if (mst == 1 && lvl >= PF) begin
         ns = 2;
      end else if (mst == 2 && pop && m_stop != 0 && m_ws == m_stop) begin
         ns = 3;
      end
      if (!play_en) ns = 0;
      if (ns == 0) q.delete();
      mst     = ns;
      m_valid = 1'b1;
   endtask

   always @(posedge rf_clk or negedge rf_rstb) begin
      if (!rf_rstb) begin
         mst = 0; q.delete(); m_data = '0; m_last = '0; m_valid = 1'b0;
         m_ws = 0; m_stop = 0; m_ucnt = 0; m_flag = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge rf_clk) begin
      if (rf_rstb) begin
         chk("state", DW'(state), DW'(mst));
         chk("m_tvalid", DW'(m_if.tvalid), DW'(m_valid));
         chk("m_tdata", m_if.tdata, m_data);
         chk("s_tready", DW'(s_if.tready), DW'((mst == 1 || mst == 2) && q.size() < DEPTH));
         chk("words_sent", DW'(words_sent), DW'(m_ws));
         chk("underflow_cnt", DW'(underflow_cnt), DW'(m_ucnt));
         chk("underflow_flag", DW'(underflow_flag), DW'(m_flag));
      end
   end

   task automatic step();
      @(negedge rf_clk);
      s_if.tdata = {8{src_next}};
   endtask

   task automatic do_reset();
      @(negedge rf_clk);
      rf_rstb = 1'b0;
      play_en = 1'b0; idle_mode = 1'b0; stat_clr = 1'b0; stop_count = '0;
      s_if.tvalid = 1'b0; m_if.tready = 1'b0;
      src_next = 1;
      s_if.tdata = {8{src_next}};
      repeat (2) @(negedge rf_clk);
      rf_rstb = 1'b1;
   endtask

   task automatic wait_state(input string nm, input int s, input int budget);
      int n = 0;
      while (state != 2'(s) && n < budget) begin
         step();
         n++;
      end
      chk(nm, DW'(state), DW'(s));
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_state"}, DW'(state), '0);
      chk({pfx, "_tvalid"}, DW'(m_if.tvalid), '0);
      chk({pfx, "_tdata"}, m_if.tdata, '0);
      chk({pfx, "_s_tready"}, DW'(s_if.tready), '0);
      chk({pfx, "_words_sent"}, DW'(words_sent), '0);
      chk({pfx, "_ucnt"}, DW'(underflow_cnt), '0);
      chk({pfx, "_uflag"}, DW'(underflow_flag), '0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rdy, saw_full;
      int unsigned first_new;
      logic [CW-1:0] one_w;
      rf_rstb = 1'b0;
      play_en = 1'b0; idle_mode = 1'b0; stat_clr = 1'b0; stop_count = '0;
      s_if.tvalid = 1'b0; m_if.tready = 1'b0; s_if.tdata = '0;
      src_next = 1;
      #3;
      check_all_zero("reset");

      // 1: continuous stream, unlimited
      do_reset();
      play_en = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      n = 0;
      do begin step(); n++; end while (!(state == 2'd2 && m_if.tdata != '0) && n < 60);
      one_w = 32'd1;
      chk("t1_first_word", m_if.tdata, {8{one_w}});
      repeat (30) step();
      chk("t1_ucnt", DW'(underflow_cnt), '0);

      // 2: stop after 20 words
      do_reset();
      stop_count = 32'd20; play_en = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      wait_state("t2_done", 3, 100);
      one_w = 32'd20;
      chk("t2_words_sent", DW'(words_sent), DW'(20));
      chk("t2_final_word", m_if.tdata, {8{one_w}});
      chk("t2_s_tready", DW'(s_if.tready), '0);
      step();
      chk("t2_idle_after", m_if.tdata, '0);
      repeat (5) step();

      // 3: underflow with hold-last idle pattern
      do_reset();
      idle_mode = 1'b1; play_en = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      wait_state("t3_play", 2, 40);
      repeat (5) step();
      s_if.tvalid = 1'b0;
      n = 0;
      do begin step(); n++; end while (!(mst == 2 && q.size() == 0) && n < 40);
      repeat (4) step();
      s_if.tvalid = 1'b1;
      repeat (3) step();
      chk("t3_ucnt", DW'(underflow_cnt), DW'(5));
      chk("t3_uflag", DW'(underflow_flag), DW'(1));
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("t3_ucnt_clr", DW'(underflow_cnt), '0);
      chk("t3_uflag_clr", DW'(underflow_flag), '0);

      // 4: DAC ready toggling, FIFO fills
      do_reset();
      play_en = 1'b1; s_if.tvalid = 1'b1;
      rdy = 0; saw_full = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         m_if.tready = ~m_if.tready;
         if (state == 2'd2 && m_if.tready) rdy++;
         if (state == 2'd2 && !s_if.tready) saw_full = 1;
      end
      step();
      chk("t4_saw_full", DW'(saw_full), DW'(1));
      chk("t4_words_vs_ready", DW'(words_sent), DW'(rdy));

      // 5: play_en dropped at level 10, then re-enabled
      do_reset();
      play_en = 1'b1; s_if.tvalid = 1'b1;
      n = 0;
      do begin step(); m_if.tready = ~m_if.tready; n++; end
         while (!(mst == 2 && q.size() == 10) && n < 80);
      play_en = 1'b0;
      step();
      chk("t5_idle", DW'(state), '0);
      chk("t5_s_tready", DW'(s_if.tready), '0);
      play_en = 1'b1;
      step();
      chk("t5_prefill", DW'(state), DW'(1));
      chk("t5_words_sent", DW'(words_sent), '0);
      first_new = src_next;
      m_if.tready = 1'b1;
      n = 0;
      do begin step(); n++; end while (!(state == 2'd2 && m_if.tdata != '0) && n < 60);
      chk("t5_first_new", m_if.tdata, {8{first_new}});

      // 6: asynchronous reset mid-PLAY
      do_reset();
      play_en = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      wait_state("t6_play", 2, 40);
      step(); step();
      #2 rf_rstb = 1'b0;
      #1 check_all_zero("t6_async");
      play_en = 1'b0;
      @(negedge rf_clk);
      rf_rstb = 1'b1;
      step();
      chk("t6_state_after", DW'(state), '0);
      chk("t6_tvalid_after", DW'(m_if.tvalid), DW'(1));

      // random traffic against the model
      do_reset();
      play_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         step();
         s_if.tvalid = ($urandom % 4) != 0;
         m_if.tready = ($urandom % 4) != 0;
         stat_clr    = ($urandom % 40) == 0;
         stop_count  = $urandom_range(0, 40);
         play_en     = ($urandom % 100) != 0;
         if (($urandom % 50) == 0) idle_mode = ~idle_mode;
      end
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
